layer_color_mapper: RTL
=======================

// Module: layer_color_mapper
// PURPOSE
//  Pipelined, parametrised pixel colour mapper for the HDMI game path. Per pixel it tests N_PLAT
//  platform segments and one ball, then emits the RGB of the highest-priority layer.
//  Host logic writes platforms into a shadow table; the table commits atomically at frame start (tear-free).
//  Sits between the VGA/HDMI timing generator and the HDMI encoder; DE is delayed to match the RGB.
// PARAMETERS
//  N_PLAT    16    number of platform table entries (1..64)
//  COORD_W   10    coordinate/length width in bits
//  HALF_T    2     platform half-thickness in pixels (vertical hit band is y-HALF_T..y+HALF_T)
//  C_PLAT    12'hC70  platform RGB444
//  C_BALL    12'hF70  ball RGB444
//  C_BG      12'h18B  background RGB444
// PORTS
//  Clk          in   1            pixel clock
//  Reset        in   1            asynchronous, active-high
//  DrawX,DrawY  in   COORD_W      current pixel coordinate
//  vde_in       in   1            active-video flag for DrawX/DrawY
//  frame_start  in   1            one-cycle pulse at the first pixel of a frame
//  BallX,BallY  in   COORD_W      ball centre (host domain, sampled at frame_start)
//  Ball_size    in   COORD_W      ball radius
//  wr_en        in   1            shadow-table write strobe
//  wr_addr      in   $clog2(N_PLAT)  entry index
//  wr_data      in   3*COORD_W+1  {valid, length, y, x_start}
//  commit_req   in   1            pulse: request shadow->active copy at next frame_start
//  Red,Green,Blue out 4           pixel colour, registered
//  vde_out      out  1            vde_in delayed by LAT
//  plat_hit     out  1            pixel lies on a valid platform (aligned with RGB)
//  plat_idx     out  $clog2(N_PLAT)  lowest hit index (0 when !plat_hit)
//  commit_pend  out  1            commit requested, not yet applied
//  commit_done  out  1            one-cycle pulse on the cycle after the active table updates
// BEHAVIOUR
//  Reset: shadow+active entries all zero (valid=0); ball regs 0; pending 0; RGB=0, vde_out=0,
//   plat_hit=0, plat_idx=0, commit_done=0. Reset mid-frame drops any pending commit.
//  Latency LAT=2: S1 registers DrawX/Y, vde, and per-entry hit vector + ball_on; S2 registers the
//   priority result into RGB/plat_hit/plat_idx. Fully pipelined, one pixel per cycle, no stalls.
//  Platform hit i: valid_i && DrawY+HALF_T >= y_i && DrawY <= y_i+HALF_T && DrawX >= x_i &&
//   DrawX <= x_i+len_i. All sums evaluated in COORD_W+2 bits (no underflow at y<HALF_T, no wrap at x+len).
//  Ball: dx=DrawX-BallX_l, dy=DrawY-BallY_l signed COORD_W+1; on when dx*dx+dy*dy <= r*r (2*COORD_W+2 bits).
//  Priority: platform > ball > background; among platforms lowest index wins plat_idx.
//  vde_out=0 -> RGB forced 0, plat_hit forced 0 (still pipelined).
//  Shadow write: wr_en writes shadow[wr_addr] on the clock edge; wr_addr>=N_PLAT ignored.
//  commit_req sets pending. frame_start && (pending||commit_req): active<=shadow (pre-edge contents;
//   a same-cycle write lands only in shadow), pending<=0, commit_done pulses next cycle.
//  BallX/BallY/Ball_size latched on every frame_start regardless of commit.
//  commit_req with no frame_start: pending stays set until next frame_start; repeated requests idempotent.
// STRUCTURE
//  Package color_mapper_pkg: COORD_W default, plat_entry_t struct {valid,len,y,x}, rgb444_t,
//   colour constants, HALF_T default.
//  Sub-module platform_hit_unit (one generate instance per entry): entry + DrawX/Y -> hit bit.
//  Top: shadow/active tables, commit FSM (IDLE/PENDING), ball latch, 2-stage pipe, priority encoder.
// TESTING
//  T1 reset: assert Reset mid-stream -> RGB=0, vde_out=0, commit_pend=0 immediately (async).
//  T2 write {1,len=100,y=200,x=50}@0, commit, frame_start; pixel (50,198),(150,202) -> RGB C70 2 cycles
//   later, plat_idx=0; (151,200),(50,203) -> background 18B.
//  T3 ball at (320,240) r=10: (330,240) -> F70; (331,240) -> 18B; platform through (320,240) -> C70 wins.
//  T4 shadow write without commit across 2 frames -> output unchanged; commit_req asserted with frame_start
//   -> applied that edge, commit_done next cycle; write same cycle -> not visible until next commit.
//  T5 boundaries: y=1 (HALF_T>y) hits DrawY=0..3; x=1000,len=100 hits to DrawX=1023 without wrap to 0;
//   overlapping entries 3 and 7 -> plat_idx=3.
//  T6 vde_in low on hit pixel -> RGB=0, plat_hit=0; random stream vs reference model, LAT=2 alignment.

Source files
------------

// File: rtl/color_mapper_pkg.sv
`default_nettype none
// ============================================================================
// color_mapper_pkg: shared types, colours and defaults for the layer colour mapper
// Revision: 1.0
// ============================================================================
package color_mapper_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int HALF_T_DEF  = 2;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t C_PLAT_DEF = 12'hC70;
    localparam rgb444_t C_BALL_DEF = 12'hF70;
    localparam rgb444_t C_BG_DEF   = 12'h18B;

    // Field order matches the host write word {valid, length, y, x_start}
    typedef struct packed {
        logic                   valid;
        logic [COORD_W_DEF-1:0] len;
        logic [COORD_W_DEF-1:0] y;
        logic [COORD_W_DEF-1:0] x;
    } plat_entry_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/platform_hit_unit.sv
`default_nettype none
// ============================================================================
// platform_hit_unit: tests one platform entry against the current pixel
// Revision: 1.0
// ============================================================================
module platform_hit_unit #(
    parameter int COORD_W = 10,
    parameter int HALF_T  = 2
) (
    input  logic [3*COORD_W:0]  entry,
    input  logic [COORD_W-1:0]  draw_x,
    input  logic [COORD_W-1:0]  draw_y,
    output logic                hit
);
    localparam int SW = COORD_W + 2;

    logic          valid;
    logic [SW-1:0] len_w, y_w, x_w, dx_w, dy_w, half_w;

    assign valid  = entry[3*COORD_W];
    assign len_w  = SW'(entry[3*COORD_W-1:2*COORD_W]);
    assign y_w    = SW'(entry[2*COORD_W-1:COORD_W]);
    assign x_w    = SW'(entry[COORD_W-1:0]);
    assign dx_w   = SW'(draw_x);
    assign dy_w   = SW'(draw_y);
    assign half_w = SW'(HALF_T);

    // Widened sums: y-HALF_T is rewritten as DrawY+HALF_T so nothing underflows
    assign hit = valid
              && (dy_w + half_w >= y_w)
              && (dy_w <= y_w + half_w)
              && (dx_w >= x_w)
              && (dx_w <= x_w + len_w);

endmodule
`default_nettype wire

// File: rtl/layer_color_mapper.sv
`default_nettype none
// ============================================================================
// layer_color_mapper: 2-stage platform/ball/background pixel colour mapper
// with a shadow platform table committed tear-free at frame start. Revision: 1.0
// ============================================================================
module layer_color_mapper
    import color_mapper_pkg::*;
#(
    parameter int      N_PLAT  = 16,
    parameter int      COORD_W = COORD_W_DEF,
    parameter int      HALF_T  = HALF_T_DEF,
    parameter rgb444_t C_PLAT  = C_PLAT_DEF,
    parameter rgb444_t C_BALL  = C_BALL_DEF,
    parameter rgb444_t C_BG    = C_BG_DEF,
    localparam int     AW      = addr_w(N_PLAT),
    localparam int     EW      = 3*COORD_W + 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               vde_in,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] BallX,
    input  logic [COORD_W-1:0] BallY,
    input  logic [COORD_W-1:0] Ball_size,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [EW-1:0]      wr_data,
    input  logic               commit_req,
    output logic [3:0]         Red,
    output logic [3:0]         Green,
    output logic [3:0]         Blue,
    output logic               vde_out,
    output logic               plat_hit,
    output logic [AW-1:0]      plat_idx,
    output logic               commit_pend,
    output logic               commit_done
);
    localparam int RW = 2*COORD_W + 2;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} commit_st_t;

    commit_st_t         state_q;
    logic               commit_done_q;
    logic               commit_fire;

    logic [EW-1:0]      shadow_q [N_PLAT];
    logic [EW-1:0]      shadow_d [N_PLAT];
    logic [EW-1:0]      active_q [N_PLAT];
    logic [EW-1:0]      active_d [N_PLAT];

    logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d, ball_r_q, ball_r_d;

    logic [N_PLAT-1:0]  hit_vec;
    logic               ball_on;
    logic [N_PLAT-1:0]  hit_s1_q;
    logic               ball_s1_q, vde_s1_q;

    rgb444_t            rgb_q, rgb_d;
    logic               hit_q, hit_d, vde_s2_q;
    logic [AW-1:0]      idx_q, idx_d;

    assign commit_fire = frame_start && ((state_q == ST_PENDING) || commit_req);

    // The copy reads pre-edge shadow contents, so a same-cycle write waits for the next commit
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en && (32'(wr_addr) < N_PLAT))
            shadow_d[wr_addr] = wr_data;
        active_d = commit_fire ? shadow_q : active_q;
        ball_x_d = frame_start ? BallX     : ball_x_q;
        ball_y_d = frame_start ? BallY     : ball_y_q;
        ball_r_d = frame_start ? Ball_size : ball_r_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            commit_done_q <= 1'b0;
        end else begin
            commit_done_q <= commit_fire;
            case (state_q)
                ST_IDLE:    if (commit_req && !frame_start) state_q <= ST_PENDING;
                ST_PENDING: if (frame_start)                state_q <= ST_IDLE;
                default:                                    state_q <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_PLAT; gi++) begin : g_plat
            platform_hit_unit #(
                .COORD_W (COORD_W),
                .HALF_T  (HALF_T)
            ) u_hit (
                .entry   (active_q[gi]),
                .draw_x  (DrawX),
                .draw_y  (DrawY),
                .hit     (hit_vec[gi])
            );
        end
    endgenerate

    logic signed [COORD_W:0] dx, dy;
    logic signed [RW-1:0]    dx_w, dy_w;
    logic        [RW-1:0]    dx_sq, dy_sq, r_sq;

    assign dx      = $signed({1'b0, DrawX}) - $signed({1'b0, ball_x_q});
    assign dy      = $signed({1'b0, DrawY}) - $signed({1'b0, ball_y_q});
    assign dx_w    = RW'(dx);
    assign dy_w    = RW'(dy);
    assign dx_sq   = dx_w * dx_w;
    assign dy_sq   = dy_w * dy_w;
    assign r_sq    = RW'(ball_r_q) * RW'(ball_r_q);
    assign ball_on = (dx_sq + dy_sq) <= r_sq;

    // Lowest index wins: scan downward so the last assignment is the smallest hit
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        for (int i = N_PLAT - 1; i >= 0; i--) begin
            if (hit_s1_q[i]) begin
                hit_d = 1'b1;
                idx_d = AW'(i);
            end
        end
        rgb_d = hit_d ? C_PLAT : (ball_s1_q ? C_BALL : C_BG);
        if (!vde_s1_q) begin
            rgb_d = '0;
            hit_d = 1'b0;
            idx_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_PLAT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            ball_x_q  <= '0;
            ball_y_q  <= '0;
            ball_r_q  <= '0;
            hit_s1_q  <= '0;
            ball_s1_q <= 1'b0;
            vde_s1_q  <= 1'b0;
            rgb_q     <= '0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            vde_s2_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            ball_r_q  <= ball_r_d;
            hit_s1_q  <= hit_vec;
            ball_s1_q <= ball_on;
            vde_s1_q  <= vde_in;
            rgb_q     <= rgb_d;
            hit_q     <= hit_d;
            idx_q     <= idx_d;
            vde_s2_q  <= vde_s1_q;
        end
    end

    assign Red         = rgb_q[11:8];
    assign Green       = rgb_q[7:4];
    assign Blue        = rgb_q[3:0];
    assign vde_out     = vde_s2_q;
    assign plat_hit    = hit_q;
    assign plat_idx    = idx_q;
    assign commit_pend = (state_q == ST_PENDING);
    assign commit_done = commit_done_q;

endmodule
`default_nettype wire
